// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch addresses over a valid/ready
// handshake and returns the stored word after WAIT_STATES wait cycles.
module imem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 200,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          WS_CNT    = 4'(WAIT_STATES);

  state_t                state_r;
  logic [3:0]            cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;
  logic                  rsp_error_r;
  logic                  busy_r;
  logic                  ready_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  rd_err_s;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_LIM);
  endfunction

  // Acceptance window: idle, out of reset, and no load competing for the array.
  always_comb begin
    ready_s = reset & (state_r == IDLE) & ~load_en;
  end

  // Read port for the RESP-entry edge; a zero-wait build reads the live request address.
  always_comb begin
    rd_addr_s = addr_r;
    rd_data_s = '0;
    rd_err_s  = 1'b0;
    if (state_r == IDLE) begin
      rd_addr_s = req_addr;
    end else begin
      rd_addr_s = addr_r;
    end
    if (in_range(rd_addr_s)) begin
      rd_data_s = mem_r[rd_addr_s];
      rd_err_s  = 1'b0;
    end else begin
      rd_data_s = '0;
      rd_err_s  = 1'b1;
    end
  end

  // Program store: no reset so contents survive a responder reset.
  always_ff @(posedge clock) begin
    if (load_en && in_range(load_addr)) begin
      mem_r[load_addr] <= load_data;
    end
  end

  // Fetch sequencer with registered response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      addr_r      <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_error_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && ready_s) begin
            addr_r <= req_addr;
            cnt_r  <= WS_CNT;
            busy_r <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= rd_data_s;
              rsp_error_r <= rd_err_s;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= rd_data_s;
            rsp_error_r <= rd_err_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_error = rsp_error_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed vector table, directed reset and
// zero-wait sequences, and random traffic against a transaction-level model.
module tb_imem_responder;
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 200;
  localparam int WS    = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_error, busy;
  logic load_en = 1'b0;
  logic [AW-1:0] req_addr = '0, load_addr = '0;
  logic [DW-1:0] load_data = '0, rsp_data;

  logic z_req_valid = 1'b0, z_req_ready, z_rsp_valid, z_rsp_ready = 1'b0, z_rsp_error, z_busy;
  logic z_load_en = 1'b0;
  logic [AW-1:0] z_req_addr = '0, z_load_addr = '0;
  logic [DW-1:0] z_load_data = '0, z_rsp_data;

  imem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy));

  imem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_addr(z_req_addr), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_data(z_rsp_data),
    .rsp_error(z_rsp_error), .load_en(z_load_en), .load_addr(z_load_addr), .load_data(z_load_data),
    .busy(z_busy));

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level reference: a pending fetch counts down edges to its response.
  logic [DW-1:0] m_mem [256];
  bit            m_pend = 1'b0;
  bit            m_hold = 1'b0;
  int            m_due  = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  bit            m_err  = 1'b0;

  typedef struct {
    logic rv; logic [AW-1:0] ra; logic rr; logic le; logic [AW-1:0] la; logic [DW-1:0] ld;
    logic e_rdy; logic e_val; logic [DW-1:0] e_data; logic e_err; logic e_busy;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic rv, input logic [AW-1:0] ra, input logic rr,
                              input logic le, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                              input logic e_rdy, input logic e_val, input logic [DW-1:0] e_data,
                              input logic e_err, input logic e_busy);
    vec_t v;
    v.rv = rv; v.ra = ra; v.rr = rr; v.le = le; v.la = la; v.ld = ld;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_data = e_data; v.e_err = e_err; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !m_pend && !m_hold && !load_en;
  endfunction

  task automatic model_respond(input logic [AW-1:0] a);
    m_pend = 1'b0;
    m_hold = 1'b1;
    m_err  = (int'(a) >= DEPTH);
    m_data = m_err ? 16'h0000 : m_mem[a];
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = model_ready();
    if (m_hold) begin
      if (rsp_ready) m_hold = 1'b0;
    end else if (m_pend) begin
      m_due--;
      if (m_due == 0) model_respond(m_addr);
    end else if (req_valid && rdy) begin
      m_addr = req_addr;
      if (WS == 0) model_respond(req_addr);
      else begin
        m_pend = 1'b1;
        m_due  = WS + 1;
      end
    end
    if (load_en && int'(load_addr) < DEPTH) m_mem[load_addr] = load_data;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic rv, input logic [AW-1:0] ra, input logic rr,
                       input logic le, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    @(negedge clock);
    req_valid = rv; req_addr = ra; rsp_ready = rr;
    load_en = le; load_addr = la; load_data = ld;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bit seen;
    seen = 1'b0;
    drive(1'b1, a, 1'b1, 1'b0, 8'h00, 16'h0000);
    #1 chk("fetch_ready", req_ready, 1'b1);
    tick();
    for (int n = 0; n < 10 && !seen; n++) begin
      drive(1'b0, a, 1'b1, 1'b0, 8'h00, 16'h0000);
      tick();
      if (rsp_valid) begin
        seen = 1'b1;
        chk("fetch_data", rsp_data, exp);
      end
    end
    chk("fetch_seen", seen, 1'b1);
    drive(1'b0, a, 1'b1, 1'b0, 8'h00, 16'h0000);
    tick();
  endtask

  initial begin
    // rv ra rr le la ld | rdy val data err busy
    tv.push_back(mk(0, 8'h00, 0, 1, 8'h00, 16'h1234, 0, 0, 16'h0000, 0, 0));
    tv.push_back(mk(0, 8'h00, 0, 1, 8'h01, 16'hABCD, 0, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 8'h00, 1, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 1, 16'h1234, 0, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 8'h01, 0, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h01, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h01, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h01, 0, 0, 8'h00, 16'h0000, 0, 1, 16'hABCD, 0, 1));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(1, 8'h55, 0, 0, 8'h00, 16'h0000, 0, 1, 16'hABCD, 0, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tv.push_back(mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 0));
    tv.push_back(mk(0, 8'h00, 0, 1, 8'hFA, 16'hBEEF, 0, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 8'hFA, 1, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 1, 16'h0000, 1, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 8'h00, 0, 1, 8'h02, 16'h7777, 0, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h00, 0, 1, 8'h00, 16'h5555, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 1, 16'h5555, 0, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 8'h01, 1, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h01, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h01, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h01, 1, 1, 8'h01, 16'h0F0F, 0, 1, 16'hABCD, 0, 1));
    tv.push_back(mk(0, 8'h01, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 8'h01, 0, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h01, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h01, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 8'h01, 0, 0, 8'h00, 16'h0000, 0, 1, 16'h0F0F, 0, 1));
    tv.push_back(mk(0, 8'h01, 0, 1, 8'h01, 16'h1111, 0, 1, 16'h0F0F, 0, 1));
    tv.push_back(mk(0, 8'h01, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 0));

    // Reset values while reset is held
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_rsp_error", rsp_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].rv, tv[i].ra, tv[i].rr, tv[i].le, tv[i].la, tv[i].ld);
      #1 chk($sformatf("v%0d_req_ready", i), req_ready, tv[i].e_rdy);
      tick();
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, tv[i].e_val);
      chk($sformatf("v%0d_busy", i), busy, tv[i].e_busy);
      if (tv[i].e_val) begin
        chk($sformatf("v%0d_rsp_data", i), rsp_data, tv[i].e_data);
        chk($sformatf("v%0d_rsp_error", i), rsp_error, tv[i].e_err);
      end
    end

    // Reset asserted in the middle of WAIT drops the request
    drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0000);
    tick();
    chk("mid_busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rsp_valid", rsp_valid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_req_ready", req_ready, 1'b0);
    m_pend = 1'b0;
    m_hold = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("post_rst_ready", req_ready, 1'b1);
    for (int n = 0; n < 5; n++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0000);
      tick();
      chk("dropped_no_rsp", rsp_valid, 1'b0);
    end
    fetch(8'h01, 16'h1111);
    fetch(8'h00, 16'h5555);
    fetch(8'h02, 16'h7777);

    // Fill the store, then random traffic against the model
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b1, 8'(a), 16'($urandom));
      tick();
    end
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 16'($urandom));
      #1 chk("rnd_req_ready", req_ready, model_ready());
      tick();
      chk("rnd_rsp_valid", rsp_valid, m_hold);
      chk("rnd_busy", busy, m_pend || m_hold);
      if (m_hold) begin
        chk("rnd_rsp_data", rsp_data, m_data);
        chk("rnd_rsp_error", rsp_error, m_err);
      end
    end

    // Zero-wait build: back-to-back fetches of 0x00..0x03
    for (int a = 0; a < 4; a++) begin
      @(negedge clock);
      z_load_en = 1'b1; z_load_addr = 8'(a); z_load_data = 16'hA000 + 16'(a);
    end
    begin
      int k, r, cyc, acc;
      logic rdy_s;
      k = 0; r = 0; cyc = 0; acc = -100;
      @(negedge clock);
      z_load_en = 1'b0;
      z_rsp_ready = 1'b1;
      while (r < 4 && cyc < 40) begin
        z_req_valid = (k < 4);
        z_req_addr = 8'(k);
        #1 rdy_s = z_req_ready;
        @(posedge clock);
        cyc++;
        #1;
        if (rdy_s && k < 4) begin
          if (k > 0) chk("ws0_interval", cyc - acc, 2);
          acc = cyc;
          k++;
        end
        if (z_rsp_valid) begin
          chk("ws0_data", z_rsp_data, 16'hA000 + 16'(r));
          chk("ws0_latency", cyc, acc);
          r++;
        end
        @(negedge clock);
      end
      chk("ws0_all_responses", r, 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
